fetch_skid_pipe_reg: RTL
========================

Name: fetch_skid_pipe_reg

Overview:
- Parametrised fetch-to-decode pipeline register for an N-lane fetch group (generalises the fixed two-lane top/bot fetch register).
- Adds a valid/ready handshake and a 2-entry skid buffer, so decode back-pressure never drops an in-flight fetch group.
- Adds a flush input that squashes both entries, and per-lane valid bits; an invalid lane presents a NOP.
- Sits between PC/imem fetch and the decode stage.

Parameters:
LANES, 2, instructions per fetch group
WIDTH, 32, bits per PC and per instruction word
NOP_INSTR, 32'h0000_0000, instruction word driven on invalid lanes and at reset

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; clears all state immediately
in_valid  in  1  upstream fetch group valid
in_ready  out  1  stage can accept a group this cycle
pc_in  in  LANES*WIDTH  lane i PC at bits [i*WIDTH +: WIDTH]
instr_in  in  LANES*WIDTH  lane i instruction, same packing
lane_valid_in  in  LANES  per-lane valid within the group
flush  in  1  squash all held groups (branch redirect)
out_valid  out  1  head group valid to decode
out_ready  in  1  decode accepts head group
pc_out  out  LANES*WIDTH  head group PCs
instr_out  out  LANES*WIDTH  head group instructions (NOP_INSTR on invalid lanes)
lane_valid_out  out  LANES  head group per-lane valid
occupancy  out  2  entries held, 0..2

Behaviour:
- Storage: main slot (head) and skid slot. occupancy counts valid slots.
- Reset (async): occupancy=0, out_valid=0, in_ready=1, pc_out=0, instr_out=NOP_INSTR on every lane, lane_valid_out=0.
- Accept = in_valid & in_ready. Deliver = out_valid & out_ready.
- in_ready = (occupancy != 2). It is combinational from registered occupancy only, with no path from out_ready, so it has no combinational path from decode.
- out_valid = (occupancy != 0). Outputs come directly from the main slot, so latency is 1 cycle when the stage is empty.
- Next-state rules per edge, by case (occupancy, accept, deliver):
  0,1,- -> main<=in, occ=1.
  1,0,1 -> occ=0.
  1,1,1 -> main<=in, occ=1.
  1,1,0 -> skid<=in, occ=2.
  2,-,1 -> main<=skid, occ=1 (accept is impossible: in_ready=0).
  2,-,0 -> hold.
- FIFO order is preserved; a group is never duplicated or dropped.
- Flush has highest priority below reset. At the edge it sets occ=0, out_valid falls next cycle, and the same-cycle accept is discarded. Slot data may remain, but outputs must show NOP_INSTR/lane_valid_out=0 while out_valid=0.
- Lane masking: for any lane with lane_valid bit 0, instr_out lane = NOP_INSTR. The PC passes through unmasked.
- A group with in_valid=1 and lane_valid_in=0 is still accepted and delivered (an all-NOP group). Decode decides whether to drop it.
- Reset asserted mid-transfer aborts everything; in_ready returns to 1 while reset is high.
- No arithmetic; widths are exact with no truncation.

Decomposition:
- Shared processor package holds:
  - NOP_INSTR default;
  - a FETCH_LANES constant;
  - a pipe_group struct/typedef (pc[LANES], instr[LANES], lane_valid) if the package style allows.
- One sub-module, fetch_slot: a WIDTH/LANES register with load enable and async reset, holding pc/instr/lane_valid. It is instantiated twice (main, skid).
- The handshake/occupancy control stays in the top module.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> occupancy=0, in_ready=1, out_valid=0, instr_out all NOP, lane_valid_out=0.
- Streaming: out_ready=1; send groups PC 0x00/0x04, 0x08/0x0C, 0x10/0x14 on consecutive cycles -> each appears exactly 1 cycle later, in order, with no bubbles.
- Back-pressure:
  - Setup: out_ready=0; send A(0x20), B(0x28).
  - Expected while held: occupancy=2, in_ready=0, C held upstream, pc_out still A.
  - Release: raise out_ready -> A, B, C delivered in order, none lost.
- Flush: occupancy=2 with flush=1 and in_valid=1 on the same edge -> next cycle occupancy=0, out_valid=0, lane_valid_out=0; the incoming group is not delivered.
- Lane mask: lane_valid_in=2'b01, instr_in lane1=0x1234_5678 -> instr_out lane1=NOP_INSTR, lane0 passes unchanged, pc_out lane1 is preserved.
- Async reset mid-stall: occupancy=2, assert reset between edges -> occupancy=0 and in_ready=1 before the next clock edge.

Source files
------------

// File: rtl/fetch_skid_pipe_reg_pkg.sv
// Shared fetch-pipeline definitions: default lane count and width, the NOP
// encoding shown on empty or masked lanes, and the fetch group record.
package fetch_skid_pipe_reg_pkg;

    localparam int FETCH_LANES = 2;
    localparam int FETCH_WIDTH = 32;
    localparam logic [31:0] FETCH_NOP_INSTR = 32'h0000_0000;

    // One fetch group as it travels from fetch to decode (default geometry).
    typedef struct packed {
        logic [FETCH_LANES-1:0][FETCH_WIDTH-1:0] pc;
        logic [FETCH_LANES-1:0][FETCH_WIDTH-1:0] instr;
        logic [FETCH_LANES-1:0]                  lane_valid;
    } pipe_group_t;

    // Number of groups held by the stage; 3 is unreachable.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/fetch_skid_pipe_reg_if.sv
// Fetch-to-decode handshake bundle. The master side is the fetch/decode
// environment, the slave side is the pipeline register itself.
interface fetch_skid_pipe_reg_if
    import fetch_skid_pipe_reg_pkg::*;
#(
    parameter int LANES = FETCH_LANES,
    parameter int WIDTH = FETCH_WIDTH
);
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] pc_in;
    logic [LANES*WIDTH-1:0] instr_in;
    logic [LANES-1:0]       lane_valid_in;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] pc_out;
    logic [LANES*WIDTH-1:0] instr_out;
    logic [LANES-1:0]       lane_valid_out;
    logic [1:0]             occupancy;

    modport master (
        output in_valid, pc_in, instr_in, lane_valid_in, flush, out_ready,
        input  in_ready, out_valid, pc_out, instr_out, lane_valid_out, occupancy
    );

    modport slave (
        input  in_valid, pc_in, instr_in, lane_valid_in, flush, out_ready,
        output in_ready, out_valid, pc_out, instr_out, lane_valid_out, occupancy
    );
endinterface

// File: rtl/fetch_skid_pipe_reg_slot.sv
// One storage slot of the fetch pipeline: a loadable register holding the
// PCs, instruction words and lane valid bits of a single fetch group.
module fetch_slot #(
    parameter int               LANES     = 2,
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_INSTR = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [LANES*WIDTH-1:0] pc_d,
    input  logic [LANES*WIDTH-1:0] instr_d,
    input  logic [LANES-1:0]       lane_valid_d,
    output logic [LANES*WIDTH-1:0] pc_q,
    output logic [LANES*WIDTH-1:0] instr_q,
    output logic [LANES-1:0]       lane_valid_q
);

    // Capture a new group on load; reset leaves a cleared, all-NOP group.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= '0;
            instr_q      <= {LANES{NOP_INSTR}};
            lane_valid_q <= '0;
        end else if (load) begin
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            lane_valid_q <= lane_valid_d;
        end else begin
            pc_q         <= pc_q;
            instr_q      <= instr_q;
            lane_valid_q <= lane_valid_q;
        end
    end

endmodule

// File: rtl/fetch_skid_pipe_reg.sv
// Fetch-to-decode pipeline register with a two-entry skid buffer. The head
// (main) slot drives decode directly; the skid slot absorbs the group that
// arrives in the cycle decode stalls, so no in-flight group is ever lost.
module fetch_skid_pipe_reg
    import fetch_skid_pipe_reg_pkg::*;
#(
    parameter int               LANES     = FETCH_LANES,
    parameter int               WIDTH     = FETCH_WIDTH,
    parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(FETCH_NOP_INSTR)
) (
    input  logic                  clk,
    input  logic                  reset,
    fetch_skid_pipe_reg_if.slave  bus
);

    occ_e                   occ_r;
    occ_e                   occ_nxt_s;
    logic                   in_ready_s;
    logic                   out_valid_s;
    logic                   accept_s;
    logic                   deliver_s;
    logic                   load_main_s;
    logic                   load_skid_s;
    logic                   main_from_skid_s;
    logic [LANES*WIDTH-1:0] main_pc_d_s;
    logic [LANES*WIDTH-1:0] main_instr_d_s;
    logic [LANES-1:0]       main_lv_d_s;
    logic [LANES*WIDTH-1:0] main_pc_s;
    logic [LANES*WIDTH-1:0] main_instr_s;
    logic [LANES-1:0]       main_lv_s;
    logic [LANES*WIDTH-1:0] skid_pc_s;
    logic [LANES*WIDTH-1:0] skid_instr_s;
    logic [LANES-1:0]       skid_lv_s;
    logic [LANES-1:0]       lane_valid_out_s;
    logic [LANES*WIDTH-1:0] instr_out_s;

    // Ready depends only on the registered count, never on out_ready.
    assign in_ready_s  = (occ_r != OCC_FULL);
    assign out_valid_s = (occ_r != OCC_EMPTY);
    assign accept_s    = bus.in_valid & in_ready_s;
    assign deliver_s   = out_valid_s & bus.out_ready;

    // Occupancy transitions and slot load selection; flush squashes everything.
    always_comb begin
        occ_nxt_s        = occ_r;
        load_main_s      = 1'b0;
        load_skid_s      = 1'b0;
        main_from_skid_s = 1'b0;
        if (bus.flush) begin
            occ_nxt_s = OCC_EMPTY;
        end else begin
            case (occ_r)
                OCC_EMPTY: begin
                    if (accept_s) begin
                        load_main_s = 1'b1;
                        occ_nxt_s   = OCC_ONE;
                    end else begin
                        occ_nxt_s   = OCC_EMPTY;
                    end
                end
                OCC_ONE: begin
                    case ({accept_s, deliver_s})
                        2'b01:   occ_nxt_s = OCC_EMPTY;
                        2'b11: begin
                            load_main_s = 1'b1;
                            occ_nxt_s   = OCC_ONE;
                        end
                        2'b10: begin
                            load_skid_s = 1'b1;
                            occ_nxt_s   = OCC_FULL;
                        end
                        default: occ_nxt_s = OCC_ONE;
                    endcase
                end
                OCC_FULL: begin
                    if (deliver_s) begin
                        main_from_skid_s = 1'b1;
                        occ_nxt_s        = OCC_ONE;
                    end else begin
                        occ_nxt_s        = OCC_FULL;
                    end
                end
                default: occ_nxt_s = OCC_EMPTY;
            endcase
        end
    end

    // Head slot refills from the skid entry when draining a full stage.
    always_comb begin
        if (main_from_skid_s) begin
            main_pc_d_s    = skid_pc_s;
            main_instr_d_s = skid_instr_s;
            main_lv_d_s    = skid_lv_s;
        end else begin
            main_pc_d_s    = bus.pc_in;
            main_instr_d_s = bus.instr_in;
            main_lv_d_s    = bus.lane_valid_in;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_r <= OCC_EMPTY;
        end else begin
            occ_r <= occ_nxt_s;
        end
    end

    fetch_slot #(.LANES(LANES), .WIDTH(WIDTH), .NOP_INSTR(NOP_INSTR)) u_main (
        .clk          (clk),
        .reset        (reset),
        .load         (load_main_s | main_from_skid_s),
        .pc_d         (main_pc_d_s),
        .instr_d      (main_instr_d_s),
        .lane_valid_d (main_lv_d_s),
        .pc_q         (main_pc_s),
        .instr_q      (main_instr_s),
        .lane_valid_q (main_lv_s)
    );

    fetch_slot #(.LANES(LANES), .WIDTH(WIDTH), .NOP_INSTR(NOP_INSTR)) u_skid (
        .clk          (clk),
        .reset        (reset),
        .load         (load_skid_s),
        .pc_d         (bus.pc_in),
        .instr_d      (bus.instr_in),
        .lane_valid_d (bus.lane_valid_in),
        .pc_q         (skid_pc_s),
        .instr_q      (skid_instr_s),
        .lane_valid_q (skid_lv_s)
    );

    // Stale slot data after a flush stays hidden: lanes show NOP unless valid.
    always_comb begin
        lane_valid_out_s = main_lv_s & {LANES{out_valid_s}};
        instr_out_s      = {LANES{NOP_INSTR}};
        for (int i = 0; i < LANES; i++) begin
            if (lane_valid_out_s[i]) begin
                instr_out_s[i*WIDTH +: WIDTH] = main_instr_s[i*WIDTH +: WIDTH];
            end else begin
                instr_out_s[i*WIDTH +: WIDTH] = NOP_INSTR;
            end
        end
    end

    assign bus.in_ready       = in_ready_s;
    assign bus.out_valid      = out_valid_s;
    assign bus.occupancy      = occ_r;
    assign bus.pc_out         = main_pc_s;
    assign bus.instr_out      = instr_out_s;
    assign bus.lane_valid_out = lane_valid_out_s;

endmodule
